// File: rtl/perm_pkg.sv
// Shared definitions for the permute-and-pipeline datapath.
//   perm_mode_e  : permutation select carried with each word
//   perm_src_idx : for output bit b, the input bit index that feeds it
package perm_pkg;

    typedef enum logic [1:0] {
        PERM_PASS      = 2'd0,
        PERM_REV_ALL   = 2'd1,
        PERM_REV_LANE  = 2'd2,
        PERM_SWAP_LANE = 2'd3
    } perm_mode_e;

    // Evaluated with constant arguments only, so each call folds to a fixed wire.
    function automatic int perm_src_idx(input int b, input int width, input int lanes,
                                        input perm_mode_e mode);
        int lw;
        int l;
        int k;
        int src;
        lw = width / lanes;
        l  = b / lw;
        k  = b % lw;
        case (mode)
            PERM_PASS:      src = b;
            PERM_REV_ALL:   src = width - 1 - b;
            PERM_REV_LANE:  src = l * lw + lw - 1 - k;
            PERM_SWAP_LANE: src = (lanes - 1 - l) * lw + k;
            default:        src = b;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/perm_reverse_pipe_stage.sv
// perm_stage: one elastic register slot with a valid/ready handshake.
//   i_clk, i_arst_n      : clock, async active-low reset
//   i_valid/o_ready/i_data : upstream side
//   o_valid/i_ready/o_data : downstream side
// Ready is combinational from downstream ready so a full chain still
// streams one word per cycle.
module perm_stage #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign o_ready = !valid_q || i_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (o_ready) begin
            valid_d = i_valid;
            if (i_valid) begin
                data_d = i_data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;

endmodule

// File: rtl/perm_reverse_pipe.sv
// perm_reverse_pipe: permutes a WIDTH-bit word on entry (mode captured per
// word) and carries it through DEPTH elastic register stages.
//   i_clk, i_arst_n          : clock, async active-low reset
//   i_valid/o_ready/i_data/i_mode : producer side
//   o_valid/i_ready/o_data   : consumer side
//   o_level                  : words currently held (0..DEPTH)
module perm_reverse_pipe
    import perm_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LANES = 1,
    parameter int DEPTH = 2
) (
    input  logic                       i_clk,
    input  logic                       i_arst_n,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [WIDTH-1:0]           i_data,
    input  logic [1:0]                 i_mode,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_level
);

    localparam int LVL_W = $clog2(DEPTH + 1);

    if (WIDTH < 1 || DEPTH < 1 || LANES < 1 || (WIDTH % LANES) != 0) begin : g_bad_param
        $error("perm_reverse_pipe: illegal WIDTH/LANES/DEPTH combination");
    end

    logic [WIDTH-1:0] rev_all_w, rev_lane_w, swap_lane_w;
    logic [WIDTH-1:0] perm_data;

    for (genvar b = 0; b < WIDTH; b++) begin : g_perm
        assign rev_all_w[b]   = i_data[perm_src_idx(b, WIDTH, LANES, PERM_REV_ALL)];
        assign rev_lane_w[b]  = i_data[perm_src_idx(b, WIDTH, LANES, PERM_REV_LANE)];
        assign swap_lane_w[b] = i_data[perm_src_idx(b, WIDTH, LANES, PERM_SWAP_LANE)];
    end

    always_comb begin
        perm_data = i_data;
        case (perm_mode_e'(i_mode))
            PERM_PASS:      perm_data = i_data;
            PERM_REV_ALL:   perm_data = rev_all_w;
            PERM_REV_LANE:  perm_data = rev_lane_w;
            PERM_SWAP_LANE: perm_data = swap_lane_w;
            default:        perm_data = i_data;
        endcase
    end

    // Index n is the link feeding stage n; index DEPTH is the output port.
    logic             stg_valid [DEPTH+1];
    logic             stg_ready [DEPTH+1];
    logic [WIDTH-1:0] stg_data  [DEPTH+1];

    assign stg_valid[0]     = i_valid;
    assign stg_data[0]      = perm_data;
    assign stg_ready[DEPTH] = i_ready;

    for (genvar n = 0; n < DEPTH; n++) begin : g_stage
        perm_stage #(.WIDTH(WIDTH)) u_stage (
            .i_clk    (i_clk),
            .i_arst_n (i_arst_n),
            .i_valid  (stg_valid[n]),
            .o_ready  (stg_ready[n]),
            .i_data   (stg_data[n]),
            .o_valid  (stg_valid[n+1]),
            .i_ready  (stg_ready[n+1]),
            .o_data   (stg_data[n+1])
        );
    end

    assign o_ready = stg_ready[0];
    assign o_valid = stg_valid[DEPTH];
    assign o_data  = stg_data[DEPTH];

    logic             accept, xfer;
    logic [LVL_W-1:0] level_q, level_d;

    assign accept = i_valid && o_ready;
    assign xfer   = o_valid && i_ready;

    always_comb begin
        level_d = level_q;
        if (accept && !xfer) begin
            level_d = level_q + LVL_W'(1);
        end else if (!accept && xfer) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign o_level = level_q;

endmodule

// File: tb/tb_perm_reverse_pipe.sv
module tb_perm_reverse_pipe;

    localparam int PW [3] = '{8, 4, 16};
    localparam int PL [3] = '{2, 1, 4};
    localparam int PD [3] = '{2, 1, 3};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  vin;
    logic [2:0]  rdy_in;
    wire  [2:0]  rdy_out;
    wire  [2:0]  vout;
    logic [15:0] din [3];
    logic [1:0]  mode_in [3];

    wire  [7:0]  dout0;
    wire  [3:0]  dout1;
    wire  [15:0] dout2;
    wire  [1:0]  lvl0;
    wire  [0:0]  lvl1;
    wire  [1:0]  lvl2;

    logic [15:0] dout [3];
    int          lvl [3];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    always_comb begin
        dout[0] = 16'(dout0);
        dout[1] = 16'(dout1);
        dout[2] = dout2;
        lvl[0]  = int'(lvl0);
        lvl[1]  = int'(lvl1);
        lvl[2]  = int'(lvl2);
    end

    perm_reverse_pipe #(.WIDTH(8), .LANES(2), .DEPTH(2)) u_dut0 (
        .i_clk(clk), .i_arst_n(rst_n), .i_valid(vin[0]), .o_ready(rdy_out[0]),
        .i_data(din[0][7:0]), .i_mode(mode_in[0]), .o_valid(vout[0]),
        .i_ready(rdy_in[0]), .o_data(dout0), .o_level(lvl0));

    perm_reverse_pipe #(.WIDTH(4), .LANES(1), .DEPTH(1)) u_dut1 (
        .i_clk(clk), .i_arst_n(rst_n), .i_valid(vin[1]), .o_ready(rdy_out[1]),
        .i_data(din[1][3:0]), .i_mode(mode_in[1]), .o_valid(vout[1]),
        .i_ready(rdy_in[1]), .o_data(dout1), .o_level(lvl1));

    perm_reverse_pipe #(.WIDTH(16), .LANES(4), .DEPTH(3)) u_dut2 (
        .i_clk(clk), .i_arst_n(rst_n), .i_valid(vin[2]), .o_ready(rdy_out[2]),
        .i_data(din[2]), .i_mode(mode_in[2]), .o_valid(vout[2]),
        .i_ready(rdy_in[2]), .o_data(dout2), .o_level(lvl2));

    // Reference model: lanes treated as small integers.
    function automatic logic [15:0] rev_bits(input logic [15:0] v, input int n);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = v[n-1-i];
        return r;
    endfunction

    function automatic logic [15:0] ref_perm(input logic [15:0] x, input int w, input int l,
                                             input int m);
        int          lw;
        logic [15:0] y, lane, lmask;
        lw    = w / l;
        lmask = 16'((32'h1 << lw) - 1);
        y     = '0;
        case (m)
            0: y = x & 16'((32'h1 << w) - 1);
            1: y = rev_bits(x, w);
            2: for (int li = 0; li < l; li++) begin
                   lane = (x >> (li * lw)) & lmask;
                   y = y | (rev_bits(lane, lw) << (li * lw));
               end
            3: for (int li = 0; li < l; li++) begin
                   lane = (x >> ((l - 1 - li) * lw)) & lmask;
                   y = y | (lane << (li * lw));
               end
            default: y = x;
        endcase
        return y;
    endfunction

    task automatic do_reset();
        vin    = '0;
        rdy_in = '0;
        #1;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        vin    = '0;
        rdy_in = '0;
        for (int k = 0; k < 3; k++) begin
            din[k]     = '0;
            mode_in[k] = '0;
        end
        rst_n = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            nvec++;
            if (vout[k] !== 1'b0 || dout[k] !== 16'h0 || lvl[k] !== 0) begin
                nerr++;
                $display("FAIL reset_state[%0d]: got v=%b d=%h l=%0d expected v=0 d=0 l=0",
                         k, vout[k], dout[k], lvl[k]);
            end
        end
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            nvec++;
            if (rdy_out[k] !== 1'b1) begin
                nerr++;
                $display("FAIL reset_ready[%0d]: got %b expected 1", k, rdy_out[k]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_modes();
        int          lvl_exp [8] = '{0, 1, 2, 2, 2, 1, 0, 0};
        logic [15:0] exp_d [4]   = '{16'hC1, 16'h83, 16'h38, 16'h1C};
        do_reset();
        rdy_in[0] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (j < 4) begin
                vin[0] = 1'b1; din[0] = 16'hC1; mode_in[0] = 2'(j);
            end else begin
                vin[0] = 1'b0;
            end
            #1;
            nvec++;
            if (rdy_out[0] !== 1'b1) begin
                nerr++; $display("FAIL modes_ready[%0d]: got %b expected 1", j, rdy_out[0]);
            end
            nvec++;
            if (lvl[0] !== lvl_exp[j]) begin
                nerr++; $display("FAIL modes_level[%0d]: got %0d expected %0d", j, lvl[0], lvl_exp[j]);
            end
            nvec++;
            if (j >= 2 && j <= 5) begin
                if (vout[0] !== 1'b1 || dout[0] !== exp_d[j-2]) begin
                    nerr++;
                    $display("FAIL modes_out[%0d]: got v=%b d=%h expected v=1 d=%h",
                             j, vout[0], dout[0], exp_d[j-2]);
                end
            end else if (vout[0] !== 1'b0) begin
                nerr++; $display("FAIL modes_idle[%0d]: got v=%b expected 0", j, vout[0]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] w [4];
        logic [1:0]  m [4];
        logic [15:0] e [4];
        int          nxt, got;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            w[i] = 16'($urandom_range(255));
            m[i] = 2'($urandom_range(3));
            e[i] = ref_perm(w[i], 8, 2, int'(m[i]));
        end
        nxt = 0;
        for (int j = 0; j < 6; j++) begin
            vin[0] = (nxt < 4);
            din[0] = w[(nxt < 4) ? nxt : 3];
            mode_in[0] = m[(nxt < 4) ? nxt : 3];
            #1;
            if (vin[0] && rdy_out[0]) nxt++;
            @(posedge clk); #1;
        end
        nvec++;
        if (nxt !== 2) begin
            nerr++; $display("FAIL bp_accepts: got %0d expected 2", nxt);
        end
        for (int j = 0; j < 3; j++) begin
            #1;
            nvec++;
            if (rdy_out[0] !== 1'b0 || lvl[0] !== 2 || vout[0] !== 1'b1 || dout[0] !== e[0]) begin
                nerr++;
                $display("FAIL bp_hold[%0d]: got r=%b l=%0d v=%b d=%h expected r=0 l=2 v=1 d=%h",
                         j, rdy_out[0], lvl[0], vout[0], dout[0], e[0]);
            end
            @(posedge clk); #1;
        end
        vin[0] = 1'b0;
        rdy_in[0] = 1'b1;
        got = 0;
        for (int j = 0; j < 6; j++) begin
            #1;
            if (vout[0] && got < 4) begin
                nvec++;
                if (dout[0] !== e[got]) begin
                    nerr++; $display("FAIL bp_drain[%0d]: got %h expected %h", got, dout[0], e[got]);
                end
                got++;
            end
            @(posedge clk); #1;
        end
        nvec++;
        if (got !== 2 || lvl[0] !== 0) begin
            nerr++; $display("FAIL bp_final: got words=%0d level=%0d expected words=2 level=0", got, lvl[0]);
        end
    endtask

    task automatic test_back_to_back_full();
        logic [15:0] w [7];
        logic [15:0] e [7];
        logic [1:0]  m [7];
        int          got;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            w[i] = 16'($urandom_range(255));
            m[i] = 2'($urandom_range(3));
            e[i] = ref_perm(w[i], 8, 2, int'(m[i]));
        end
        for (int i = 0; i < 2; i++) begin
            vin[0] = 1'b1; din[0] = w[i]; mode_in[0] = m[i];
            #1;
            nvec++;
            if (rdy_out[0] !== 1'b1) begin
                nerr++; $display("FAIL full_fill_ready[%0d]: got %b expected 1", i, rdy_out[0]);
            end
            @(posedge clk); #1;
        end
        rdy_in[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din[0] = w[i+2]; mode_in[0] = m[i+2];
            #1;
            nvec++;
            if (rdy_out[0] !== 1'b1 || lvl[0] !== 2 || vout[0] !== 1'b1 || dout[0] !== e[i]) begin
                nerr++;
                $display("FAIL full_stream[%0d]: got r=%b l=%0d v=%b d=%h expected r=1 l=2 v=1 d=%h",
                         i, rdy_out[0], lvl[0], vout[0], dout[0], e[i]);
            end
            @(posedge clk); #1;
        end
        vin[0] = 1'b0;
        #1;
        nvec++;
        if (lvl[0] !== 2) begin
            nerr++; $display("FAIL full_level_after: got %0d expected 2", lvl[0]);
        end
        got = 5;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) #1;
            if (vout[0] && got < 7) begin
                nvec++;
                if (dout[0] !== e[got]) begin
                    nerr++; $display("FAIL full_drain[%0d]: got %h expected %h", got, dout[0], e[got]);
                end
                got++;
            end
            @(posedge clk); #1;
        end
        nvec++;
        if (got !== 7 || lvl[0] !== 0) begin
            nerr++; $display("FAIL full_final: got words=%0d level=%0d expected words=7 level=0", got, lvl[0]);
        end
    endtask

    task automatic test_mid_reset();
        bit seen;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            vin[0] = 1'b1; din[0] = 16'($urandom_range(255)); mode_in[0] = 2'($urandom_range(3));
            @(posedge clk); #1;
        end
        vin[0] = 1'b0;
        #1;
        nvec++;
        if (vout[0] !== 1'b1 || lvl[0] !== 2) begin
            nerr++; $display("FAIL mrst_pre: got v=%b l=%0d expected v=1 l=2", vout[0], lvl[0]);
        end
        rst_n = 1'b0;
        #1;
        nvec++;
        if (vout[0] !== 1'b0 || dout[0] !== 16'h0 || lvl[0] !== 0) begin
            nerr++;
            $display("FAIL mrst_async: got v=%b d=%h l=%0d expected v=0 d=0 l=0", vout[0], dout[0], lvl[0]);
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vin[0] = 1'b1; din[0] = 16'hA5; mode_in[0] = 2'd1; rdy_in[0] = 1'b1;
        @(posedge clk); #1;
        vin[0] = 1'b0;
        seen = 1'b0;
        for (int j = 0; j < 6; j++) begin
            #1;
            if (vout[0]) begin
                nvec++;
                if (dout[0] !== 16'hA5) begin
                    nerr++; $display("FAIL mrst_next: got %h expected a5", dout[0]);
                end
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) begin
            nvec++; nerr++;
            $display("FAIL mrst_timeout: got no output expected a5");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mode_stall();
        int got;
        do_reset();
        vin[0] = 1'b1; din[0] = 16'h0F; mode_in[0] = 2'd1;
        @(posedge clk); #1;
        din[0] = 16'h0F; mode_in[0] = 2'd3;
        @(posedge clk); #1;
        vin[0] = 1'b0; din[0] = 16'hFF; mode_in[0] = 2'd0;
        for (int j = 0; j < 2; j++) begin
            #1;
            nvec++;
            if (vout[0] !== 1'b1 || dout[0] !== 16'hF0 || lvl[0] !== 2) begin
                nerr++;
                $display("FAIL mstall_hold[%0d]: got v=%b d=%h l=%0d expected v=1 d=f0 l=2",
                         j, vout[0], dout[0], lvl[0]);
            end
            @(posedge clk); #1;
        end
        rdy_in[0] = 1'b1;
        got = 0;
        for (int j = 0; j < 5; j++) begin
            #1;
            if (vout[0]) begin
                nvec++;
                if (dout[0] !== 16'hF0) begin
                    nerr++; $display("FAIL mstall_out[%0d]: got %h expected f0", got, dout[0]);
                end
                got++;
            end
            @(posedge clk); #1;
        end
        nvec++;
        if (got !== 2) begin
            nerr++; $display("FAIL mstall_count: got %0d expected 2", got);
        end
    endtask

    task automatic test_random_sweep();
        logic [15:0] exp_q [3][32];
        int          acc_t [3][32];
        int          hd [3], cnt [3];
        bit          pacc [3], pxfer [3];
        logic [15:0] pval [3];
        do_reset();
        for (int k = 0; k < 3; k++) begin
            hd[k] = 0; cnt[k] = 0; pacc[k] = 1'b0; pxfer[k] = 1'b0; pval[k] = '0;
        end
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (pxfer[k] && cnt[k] > 0) begin
                    hd[k] = (hd[k] + 1) % 32;
                    cnt[k]--;
                end
                if (pacc[k]) begin
                    exp_q[k][(hd[k] + cnt[k]) % 32] = pval[k];
                    acc_t[k][(hd[k] + cnt[k]) % 32] = c;
                    cnt[k]++;
                end
                nvec++;
                if (lvl[k] !== cnt[k] || lvl[k] > PD[k]) begin
                    nerr++; $display("FAIL sweep_level[%0d] c=%0d: got %0d expected %0d", k, c, lvl[k], cnt[k]);
                end
                nvec++;
                if (cnt[k] == 0 && vout[k] !== 1'b0) begin
                    nerr++; $display("FAIL sweep_empty[%0d] c=%0d: got v=%b expected 0", k, c, vout[k]);
                end else if (cnt[k] > 0 && vout[k] === 1'b1 && dout[k] !== exp_q[k][hd[k]]) begin
                    nerr++;
                    $display("FAIL sweep_data[%0d] c=%0d: got %h expected %h", k, c, dout[k], exp_q[k][hd[k]]);
                end else if (cnt[k] > 0 && (c - acc_t[k][hd[k]]) >= PD[k] - 1 && vout[k] !== 1'b1) begin
                    nerr++; $display("FAIL sweep_latency[%0d] c=%0d: got v=%b expected 1", k, c, vout[k]);
                end
                vin[k]     = ($urandom_range(3) < ((c / 40) % 4) + 1);
                rdy_in[k]  = ($urandom_range(3) < ((c / 55) % 4) + 1);
                din[k]     = 16'($urandom) & 16'((32'h1 << PW[k]) - 1);
                mode_in[k] = 2'($urandom_range(3));
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                nvec++;
                if (rdy_out[k] !== ((cnt[k] < PD[k]) || rdy_in[k])) begin
                    nerr++;
                    $display("FAIL sweep_ready[%0d] c=%0d: got %b expected %b", k, c, rdy_out[k],
                             ((cnt[k] < PD[k]) || rdy_in[k]));
                end
                pacc[k]  = vin[k] && rdy_out[k];
                pxfer[k] = vout[k] && rdy_in[k];
                pval[k]  = ref_perm(din[k], PW[k], PL[k], int'(mode_in[k]));
            end
            @(posedge clk); #1;
        end
        vin = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_back_to_back_full();
        test_mid_reset();
        test_mode_stall();
        test_random_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
